mdu_ctrl: RTL and testbench

Sequencing controller for the multiply/divide unit in the five-stage MIPS pipeline. It accepts mult/div/move-to-HI/LO requests from the E stage and computes the result at start. It holds that result for a fixed multi-cycle latency while signalling busy, then commits it to the architectural HI/LO registers. It also raises the D-stage stall for any MDU-dependent instruction that would otherwise observe stale HI/LO.

---
 rtl/mdu_ctrl_pkg.sv | 25 ++
 rtl/mdu_calc.sv | 60 ++++++
 rtl/mdu_ctrl.sv | 136 +++++++++++++
 tb/tb_mdu_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared types and default latencies for the multiply/divide unit controller.
package mdu_ctrl_pkg;

  // E-stage MDU op encoding carried on req_op_e
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } mdu_op_e;

  // Sequencer state
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_calc.sv
// Combinational MDU datapath: full 64-bit products and 32-bit quotient/remainder
// for the four arithmetic ops. Non-arithmetic ops yield zero results.
module mdu_calc
  import mdu_ctrl_pkg::*;
(
  input  mdu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic               is_div;
  logic               div_ovf;
  logic [31:0]        div_s_b;
  logic [31:0]        div_u_b;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;

  // Sign-extended operands make the low 64 bits of an unsigned multiply equal
  // the signed product, so no signed-arithmetic context is needed here.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
  assign div_zero = is_div && (b == 32'd0);

  // Divisor 1 replaces both zero (result discarded anyway) and the
  // 0x80000000 / -1 overflow case; dividing by 1 yields exactly the required
  // quotient 0x80000000 and remainder 0 without a trapping division.
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign div_s_b = ((b == 32'd0) || div_ovf) ? 32'd1 : b;
  assign div_u_b = (b == 32'd0) ? 32'd1 : b;

  // Signed division truncates toward zero; remainder takes the dividend sign.
  assign quot_s = $signed(a) / $signed(div_s_b);
  assign rem_s  = $signed(a) % $signed(div_s_b);
  assign quot_u = a / div_u_b;
  assign rem_u  = a % div_u_b;

  // Select the result pair for the requested op
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch.
    res_hi = '0;
    res_lo = '0;
    case (op)
      OP_MULT:  begin res_hi = prod_s[63:32];  res_lo = prod_s[31:0];    end
      OP_MULTU: begin res_hi = prod_u[63:32];  res_lo = prod_u[31:0];    end
      OP_DIV:   begin res_hi = 32'(rem_s);     res_lo = 32'(quot_s);     end
      OP_DIVU:  begin res_hi = rem_u;          res_lo = quot_u;          end
      default:  ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencing controller: starts mult/div from E stage, holds the result for
// a fixed latency while busy, then commits to HI/LO. Drives the D-stage stall.
// Optional feature: define MDU_CTRL_PERF_EN to build the stall-cycle counter;
// otherwise stall_cycles is tied to zero.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_e,
  input  logic [2:0]  req_op_e,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  input  logic        d_is_mdu,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_d,
  output logic [31:0] stall_cycles
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      hi_q, lo_q;
  logic [31:0]      pend_hi_q, pend_lo_q;
  logic             pend_zero_q;

  mdu_op_e          op;
  logic             is_arith;
  logic             is_div;
  logic             start;
  logic             move_hi;
  logic             move_lo;
  logic             commit;
  logic [31:0]      res_hi, res_lo;
  logic             div_zero;

  assign op       = mdu_op_e'(req_op_e);
  assign is_arith = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  assign is_div   = op inside {OP_DIV, OP_DIVU};
  assign busy     = (state_q == ST_BUSY);

  // Requests arriving while busy are dropped silently.
  assign start   = req_valid_e && is_arith && !busy;
  assign move_hi = req_valid_e && (op == OP_MTHI) && !busy;
  assign move_lo = req_valid_e && (op == OP_MTLO) && !busy;

  // Same-cycle start must stall too, so this stays purely combinational.
  assign stall_d = d_is_mdu && (busy || start);

  assign hi = hi_q;
  assign lo = lo_q;

  mdu_calc u_calc (
    .op       (op),
    .a        (rs_e),
    .b        (rt_e),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and commit decision; commit is skipped for divide by zero
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_BUSY;
      ST_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          commit  = !pend_zero_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latency counter, pending result capture and architectural HI/LO update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_zero_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (start) begin
        cnt_q       <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        pend_hi_q   <= res_hi;
        pend_lo_q   <= res_lo;
        pend_zero_q <= div_zero;
      end else if (busy) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      // Commit and moves are exclusive: moves are only accepted when idle.
      if (commit) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end else begin
        if (move_hi) hi_q <= rs_e;
        if (move_lo) lo_q <= rs_e;
      end
    end
  end

`ifdef MDU_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;

  // Count every edge on which the D stage is held; wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       stall_cnt_q <= '0;
    else if (stall_d) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed testbench for mdu_ctrl with hand-computed expected values.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid_e;
  logic [2:0]  req_op_e;
  logic [31:0] rs_e;
  logic [31:0] rt_e;
  logic        d_is_mdu;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_d;
  logic [31:0] stall_cycles;

  int n_vec;
  int n_miss;

`ifdef MDU_CTRL_PERF_EN
  localparam logic [31:0] EXP_STALLS = 32'd6;
`else
  localparam logic [31:0] EXP_STALLS = 32'd0;
`endif

  mdu_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_e  (req_valid_e),
    .req_op_e     (req_op_e),
    .rs_e         (rs_e),
    .rt_e         (rt_e),
    .d_is_mdu     (d_is_mdu),
    .hi           (hi),
    .lo           (lo),
    .busy         (busy),
    .stall_d      (stall_d),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request for one cycle; returns #1 after the accepting edge.
  task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid_e = 1'b1;
    req_op_e    = op;
    rs_e        = a;
    rt_e        = b;
    @(posedge clk);
    #1 req_valid_e = 1'b0;
  endtask

  // Count busy cycles seen at negedges; returns in the first idle cycle.
  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int n;
    n_vec       = 0;
    n_miss      = 0;
    reset       = 1'b0;
    req_valid_e = 1'b0;
    req_op_e    = 3'd0;
    rs_e        = '0;
    rt_e        = '0;
    d_is_mdu    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall_d}, 32'd0);
    check("rst_stall_cycles", stall_cycles, 32'd0);
    reset = 1'b1;

    // MULT -1 x 2 = -2
    issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_idle(n);
    check("mult_busy_cycles", 32'(n), 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);

    // MULTU 0xFFFFFFFF x 2 = 0x1_FFFFFFFE
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_idle(n);
    check("multu_busy_cycles", 32'(n), 32'd5);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    // DIV -7 / 2 = -3 rem -1
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_idle(n);
    check("div_busy_cycles", 32'(n), 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // DIV overflow special case
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0000_0000);

    // DIVU 100 / 7 = 14 rem 2, with an MTLO attempted while busy
    issue(OP_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    req_valid_e = 1'b1;
    req_op_e    = OP_MTLO;
    rs_e        = 32'h0000_DEAD;
    @(posedge clk);
    #1 req_valid_e = 1'b0;
    @(negedge clk);
    check("busy_mtlo_ignored", lo, 32'h8000_0000);
    check("busy_mid_divu", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("divu_rest_cycles", 32'(n), 32'd8);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    // MTHI/MTLO preload, no busy
    issue(OP_MTHI, 32'h0000_0011, 32'd0);
    @(negedge clk);
    check("mthi_hi", hi, 32'h0000_0011);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    issue(OP_MTLO, 32'h0000_0022, 32'd0);
    @(negedge clk);
    check("mtlo_lo", lo, 32'h0000_0022);
    check("mtlo_hi_kept", hi, 32'h0000_0011);

    // DIVU 5 / 0: full latency, no commit
    issue(OP_DIVU, 32'd5, 32'd0);
    wait_idle(n);
    check("divz_busy_cycles", 32'(n), 32'd10);
    check("divz_hi", hi, 32'h0000_0011);
    check("divz_lo", lo, 32'h0000_0022);

    // Stall: clean counter first, then MULT with d_is_mdu held high
    do_reset();
    @(negedge clk);
    d_is_mdu = 1'b1;
    #1 check("stall_idle", {31'd0, stall_d}, 32'd0);
    req_valid_e = 1'b1;
    req_op_e    = OP_MULT;
    rs_e        = 32'd3;
    rt_e        = 32'd4;
    #1 check("stall_start_cycle", {31'd0, stall_d}, 32'd1);
    @(posedge clk);
    #1 req_valid_e = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (stall_d) n++;
    end
    check("stall_busy_cycles", 32'(n), 32'd5);
    @(negedge clk);
    check("stall_after", {31'd0, stall_d}, 32'd0);
    check("stall_mult_lo", lo, 32'd12);
    check("stall_cycles", stall_cycles, EXP_STALLS);

    // Reset in the 4th busy cycle of a DIV aborts it
    issue(OP_MTHI, 32'h0000_AAAA, 32'd0);
    issue(OP_MTLO, 32'h0000_5555, 32'd0);
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_stall", {31'd0, stall_d}, 32'd0);
    check("abort_stall_cycles", stall_cycles, 32'd0);
    @(negedge clk);
    reset    = 1'b1;
    d_is_mdu = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_no_commit_hi", hi, 32'd0);
    check("abort_no_commit_lo", lo, 32'd0);
    check("abort_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
